// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit in front of the byte-addressed data RAM.
//
// The unit takes one request at a time from execute, checking the opcode,
// alignment and bounds. A legal request drives the RAM controls for exactly
// one ACCESS cycle. Every request, including a faulting one, produces one
// registered response. That response is held until writeback accepts it.
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_req_valid / o_req_ready   request handshake (ready only in IDLE)
//   i_req_op/addr/wdata/rd      MIPS major opcode, byte address, store data, dest tag
//   o_mem_addr/rsize/rsign      RAM read controls (sizes 1/2/4, 0 = idle)
//   o_mem_wsize/wdata           RAM write controls (RAM writes when wsize != 0)
//   i_mem_rdata                 combinational, already extended RAM read data
//   o_resp_valid / i_resp_ready response handshake
//   o_resp_data/rd/wen          load result, echoed tag, register write enable
//   o_resp_exc/cause/badaddr    fault flag, cause (1 misalign, 2 bounds, 3 opcode), address

`ifndef MEM_SIZE
`define MEM_SIZE 4096
`endif

module mem_lsu #(
  parameter int unsigned MEM_BYTES = `MEM_SIZE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic [31:0] o_mem_addr,
  output logic [2:0]  o_mem_rsize,
  output logic        o_mem_rsign,
  output logic [2:0]  o_mem_wsize,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_data,
  output logic [4:0]  o_resp_rd,
  output logic        o_resp_wen,
  output logic        o_resp_exc,
  output logic [1:0]  o_resp_cause,
  output logic [31:0] o_resp_badaddr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, state_next;

  logic [2:0]  req_size;
  logic        req_sign;
  logic        req_load;
  logic        req_misaligned;
  logic        req_oob;
  logic [1:0]  req_cause;
  logic [32:0] req_end;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_size;
  logic        cap_sign;
  logic        cap_load;
  logic [4:0]  cap_rd;

  // Decode the incoming opcode and classify the request. A size of zero
  // marks an illegal opcode. The end address is formed in 33 bits so that
  // requests near 0xFFFFFFFF cannot wrap back into range.
  always_comb begin
    req_size = 3'd0;
    req_sign = 1'b0;
    req_load = 1'b0;
    case (i_req_op)
      6'h20: begin req_size = 3'd1; req_sign = 1'b1; req_load = 1'b1; end
      6'h21: begin req_size = 3'd2; req_sign = 1'b1; req_load = 1'b1; end
      6'h23: begin req_size = 3'd4; req_load = 1'b1; end
      6'h24: begin req_size = 3'd1; req_load = 1'b1; end
      6'h25: begin req_size = 3'd2; req_load = 1'b1; end
      6'h28: req_size = 3'd1;
      6'h29: req_size = 3'd2;
      6'h2B: req_size = 3'd4;
      default: ;
    endcase
    req_misaligned = ((req_size == 3'd2) && i_req_addr[0]) ||
                     ((req_size == 3'd4) && (i_req_addr[1:0] != 2'b00));
    req_end = {1'b0, i_req_addr} + {30'd0, req_size};
    req_oob = (req_end > MEM_LIMIT);
    if (req_size == 3'd0)
      req_cause = 2'd3;
    else if (req_misaligned)
      req_cause = 2'd1;
    else if (req_oob)
      req_cause = 2'd2;
    else
      req_cause = 2'd0;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic and the handshake and RAM control outputs. RAM
  // controls are only nonzero during ACCESS. The write size is also gated by
  // reset so that a store caught by reset never reaches the RAM.
  always_comb begin
    state_next   = state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_mem_addr   = 32'd0;
    o_mem_rsize  = 3'd0;
    o_mem_rsign  = 1'b0;
    o_mem_wsize  = 3'd0;
    o_mem_wdata  = 32'd0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid)
          state_next = (req_cause == 2'd0) ? ACCESS : RESP;
      end
      ACCESS: begin
        o_mem_addr = cap_addr;
        if (cap_load) begin
          o_mem_rsize = cap_size;
          o_mem_rsign = cap_sign;
        end else begin
          o_mem_wsize = i_rst_n ? cap_size : 3'd0;
          o_mem_wdata = cap_wdata;
        end
        state_next = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and the response registers. A faulting request fills the
  // response directly from IDLE. A legal one fills it at the end of ACCESS.
  // The response registers stay at zero outside RESP.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cap_addr       <= 32'd0;
      cap_wdata      <= 32'd0;
      cap_size       <= 3'd0;
      cap_sign       <= 1'b0;
      cap_load       <= 1'b0;
      cap_rd         <= 5'd0;
      o_resp_data    <= 32'd0;
      o_resp_rd      <= 5'd0;
      o_resp_wen     <= 1'b0;
      o_resp_exc     <= 1'b0;
      o_resp_cause   <= 2'd0;
      o_resp_badaddr <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            cap_addr  <= i_req_addr;
            cap_wdata <= i_req_wdata;
            cap_size  <= req_size;
            cap_sign  <= req_sign;
            cap_load  <= req_load;
            cap_rd    <= i_req_rd;
            if (req_cause != 2'd0) begin
              o_resp_data    <= 32'd0;
              o_resp_rd      <= i_req_rd;
              o_resp_wen     <= 1'b0;
              o_resp_exc     <= 1'b1;
              o_resp_cause   <= req_cause;
              o_resp_badaddr <= i_req_addr;
            end
          end
        end
        ACCESS: begin
          o_resp_rd      <= cap_rd;
          o_resp_exc     <= 1'b0;
          o_resp_cause   <= 2'd0;
          o_resp_badaddr <= 32'd0;
          o_resp_data    <= cap_load ? i_mem_rdata : 32'd0;
          o_resp_wen     <= cap_load;
        end
        RESP: begin
          if (i_resp_ready) begin
            o_resp_data    <= 32'd0;
            o_resp_rd      <= 5'd0;
            o_resp_wen     <= 1'b0;
            o_resp_exc     <= 1'b0;
            o_resp_cause   <= 2'd0;
            o_resp_badaddr <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
